// File: rtl/spmv_pkg.sv
// Types and constants shared by the SpMV encoder (RAM loader) and the SpMV PE.
package spmv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StFlush,
    StDone
  } state_e;

  localparam int unsigned EntryValueW = 16;
  localparam int unsigned EntryColW   = 16;

  // EOR flag encoding seen by the PE: 0 closes a row, 1 means the row continues.
  localparam logic EOR_LAST = 1'b0;
  localparam logic EOR_MORE = 1'b1;

  typedef struct packed {
    logic [EntryValueW-1:0] value;
    logic [EntryColW-1:0]   col;
    logic                   eor;
  } entry_t;

endpackage

// File: rtl/spmv_rc_counter.sv
// Row/column position of the dense row-major stream, with end-of-row and last-row flags.
module spmv_rc_counter #(
  parameter int unsigned NDim = 16,
  parameter int unsigned CntW = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            adv_i,
  output logic [CntW-1:0] row_o,
  output logic [CntW-1:0] col_o,
  output logic            last_col_o,
  output logic            last_row_o
);

  localparam logic [CntW-1:0] Last = CntW'(NDim - 1);

  logic [CntW-1:0] row_q, row_d;
  logic [CntW-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (adv_i) begin
      if (col_q == Last) begin
        col_d = '0;
        row_d = (row_q == Last) ? '0 : row_q + CntW'(1);
      end else begin
        col_d = col_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o      = row_q;
  assign col_o      = col_q;
  assign last_col_o = (col_q == Last);
  assign last_row_o = (row_q == Last);

endmodule

// File: rtl/spmv_encoder.sv
// Dense symmetric matrix stream to compressed (value, col, EOR) upper-triangle entries,
// written through a shared val/col/eor RAM write port.
module spmv_encoder
  import spmv_pkg::*;
#(
  parameter int unsigned N_DIM       = 16,
  parameter int unsigned WIDTH_value = 16,
  parameter int unsigned WIDTH_col   = 16,
  parameter int unsigned WIDTH_ADDR  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH_value-1:0] in_data,
  output logic                  wr_en,
  output logic [WIDTH_ADDR-1:0] wr_addr,
  output logic [WIDTH_value-1:0] wr_value,
  output logic [WIDTH_col-1:0]  wr_col,
  output logic                  wr_eor,
  output logic [WIDTH_ADDR:0]   nnz,
  output logic                  done,
  output logic                  overflow
);

  localparam int unsigned CntW = (N_DIM > 1) ? $clog2(N_DIM) : 1;
  localparam logic [WIDTH_ADDR:0] Depth = {1'b1, {WIDTH_ADDR{1'b0}}};
  localparam logic [WIDTH_ADDR:0] NnzOne = {{WIDTH_ADDR{1'b0}}, 1'b1};

  state_e                state_q, state_d;
  entry_t                pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  entry_t                cap_q, cap_d;
  logic                  cap_last_q, cap_last_d;
  entry_t                wr_q, wr_d;
  logic                  wr_en_q, wr_en_d;
  logic [WIDTH_ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH_ADDR:0]   nnz_q, nnz_d;
  logic                  ovf_q, ovf_d;

  logic [CntW-1:0] row, col;
  logic            last_col, last_row;
  logic            cnt_clr, accept, keep;
  logic            wr_req;
  entry_t          wr_ent, beat;

  assign in_ready = (state_q == StStream);
  assign done     = (state_q == StDone);
  assign accept   = in_valid && in_ready;
  // Diagonal always survives so every row ends with at least one entry.
  assign keep     = (col == row) || ((col > row) && (in_data != '0));
  assign beat     = '{value: EntryValueW'(in_data), col: EntryColW'(col), eor: EOR_LAST};

  spmv_rc_counter #(
    .NDim (N_DIM),
    .CntW (CntW)
  ) u_rc_counter (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clr_i      (cnt_clr),
    .adv_i      (accept),
    .row_o      (row),
    .col_o      (col),
    .last_col_o (last_col),
    .last_row_o (last_row)
  );

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cap_d      = cap_q;
    cap_last_d = cap_last_q;
    wr_d       = wr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    nnz_d      = nnz_q;
    ovf_d      = ovf_q;
    cnt_clr    = 1'b0;
    wr_req     = 1'b0;
    wr_ent     = pend_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StStream;
          cnt_clr    = 1'b1;
          nnz_d      = '0;
          ovf_d      = 1'b0;
          pend_vld_d = 1'b0;
        end
      end
      StStream: begin
        if (accept) begin
          if (last_col) begin
            pend_vld_d = 1'b0;
            if (keep) begin
              // Pending is empty only on the last row, where the row-end beat is the diagonal.
              wr_req     = pend_vld_q;
              wr_ent.eor = EOR_MORE;
              cap_d      = beat;
              cap_last_d = last_row;
              state_d    = StFlush;
            end else begin
              wr_req     = 1'b1;
              wr_ent.eor = EOR_LAST;
              if (last_row) begin
                state_d = StDone;
              end
            end
          end else if (keep) begin
            wr_req     = pend_vld_q;
            wr_ent.eor = EOR_MORE;
            pend_d     = beat;
            pend_vld_d = 1'b1;
          end
        end
      end
      StFlush: begin
        wr_req     = 1'b1;
        wr_ent     = cap_q;
        wr_ent.eor = EOR_LAST;
        state_d    = cap_last_q ? StDone : StStream;
      end
      default: state_d = StIdle;
    endcase

    if (wr_req) begin
      if (nnz_q == Depth) begin
        ovf_d = 1'b1;
      end else begin
        wr_en_d   = 1'b1;
        wr_d      = wr_ent;
        wr_addr_d = nnz_q[WIDTH_ADDR-1:0];
        nnz_d     = nnz_q + NnzOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cap_q      <= '0;
      cap_last_q <= 1'b0;
      wr_q       <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      nnz_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cap_q      <= cap_d;
      cap_last_q <= cap_last_d;
      wr_q       <= wr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      nnz_q      <= nnz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_value = WIDTH_value'(wr_q.value);
  assign wr_col   = WIDTH_col'(wr_q.col);
  assign wr_eor   = wr_q.eor;
  assign nnz      = nnz_q;
  assign overflow = ovf_q;

endmodule
